// File: rtl/timer_alarm_pkg.sv
// Shared constants, register map and per-channel state for the alarm timer.
package timer_alarm_pkg;

  localparam int unsigned CNT_W_MAX = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TIME_W    = 16;
  localparam int unsigned ADDR_W    = 5;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_PENDING  = 2;
  localparam int unsigned CTRL_IRQ_EN   = 3;

  typedef struct packed {
    logic                 enable;
    logic                 periodic;
    logic                 pending;
    logic                 irq_en;
    logic [CNT_W_MAX-1:0] reload;
    logic [CNT_W_MAX-1:0] count;
  } chan_state_t;

  // CTRL register image as seen on the bus; unused bits read 0.
  function automatic logic [DATA_W-1:0] ctrl_word(input chan_state_t s);
    logic [DATA_W-1:0] w;
    w                = '0;
    w[CTRL_ENABLE]   = s.enable;
    w[CTRL_PERIODIC] = s.periodic;
    w[CTRL_PENDING]  = s.pending;
    w[CTRL_IRQ_EN]   = s.irq_en;
    return w;
  endfunction

endpackage

// File: rtl/timer_alarm_channel.sv
// One countdown alarm channel: CTRL/RELOAD registers, countdown and pending flag.
module timer_alarm_channel
  import timer_alarm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_ctrl,
  input  logic              wr_reload,
  input  logic [DATA_W-1:0] wdata,
  output chan_state_t       state
);

  chan_state_t state_nxt;
  logic        expire_c;
  logic        en_req_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= '0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    expire_c  = tick && state.enable && (state.count == CNT_W_MAX'(1));
    en_req_c  = wdata[CTRL_ENABLE] && (state.reload != '0);

    if (tick && state.enable) begin
      if (expire_c) begin
        if (state.periodic) begin
          state_nxt.count = state.reload;
        end else begin
          state_nxt.count  = '0;
          state_nxt.enable = 1'b0;
        end
      end else begin
        state_nxt.count = state.count - CNT_W_MAX'(1);
      end
    end

    // CTRL write overrides the countdown: an arming write loads, a disarming write freezes.
    if (wr_ctrl) begin
      state_nxt.periodic = wdata[CTRL_PERIODIC];
      state_nxt.irq_en   = wdata[CTRL_IRQ_EN];
      if (en_req_c && !state_nxt.enable) begin
        state_nxt.count = state.reload;
      end else if (!wdata[CTRL_ENABLE] && state.enable) begin
        state_nxt.count = state.count;
      end
      state_nxt.enable = en_req_c;
      if (wdata[CTRL_PENDING]) state_nxt.pending = 1'b0;
    end

    if (wr_reload) state_nxt.reload = CNT_W_MAX'(wdata[CNT_W-1:0]);

    // Expiry beats a same-cycle clear.
    if (expire_c) state_nxt.pending = 1'b1;
  end

endmodule

// File: rtl/timer_alarm.sv
// Alarm timer top: tick detection on time_ms4, register bus decode/read mux, irq.
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TIME_W-1:0] time_ms4,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rvalid,
  output logic              irq
);

  logic [TIME_W-1:0] prev_ms4;
  logic              tick_armed;
  logic              tick_c;
  logic [2:0]        ch_idx;
  logic [1:0]        reg_idx;
  logic              ch_valid_c;
  logic [DATA_W-1:0] rdata_c;
  logic              irq_c;
  chan_state_t       sel_c;
  chan_state_t       ch_state [CHANNELS];

  assign ch_idx     = bus_addr[4:2];
  assign reg_idx    = bus_addr[1:0];
  assign ch_valid_c = 32'(ch_idx) < CHANNELS;

  // Only an exact +1 step (mod 2^16) counts; any other change just resyncs.
  assign tick_c = tick_armed && (time_ms4 == prev_ms4 + TIME_W'(1));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr_ctrl_c;
    logic wr_reload_c;
    assign wr_ctrl_c   = bus_wr && (ch_idx == 3'(i)) && (reg_idx == REG_CTRL);
    assign wr_reload_c = bus_wr && (ch_idx == 3'(i)) && (reg_idx == REG_RELOAD);

    timer_alarm_channel #(.CNT_W(CNT_W)) u_ch (
      .clock     (clock),
      .reset     (reset),
      .tick      (tick_c),
      .wr_ctrl   (wr_ctrl_c),
      .wr_reload (wr_reload_c),
      .wdata     (bus_wdata),
      .state     (ch_state[i])
    );
  end

  always_comb begin
    sel_c   = '0;
    rdata_c = '0;
    irq_c   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_idx == 3'(i)) sel_c = ch_state[i];
      irq_c = irq_c | (ch_state[i].pending & ch_state[i].irq_en);
    end
    if (ch_valid_c) begin
      case (reg_idx)
        REG_CTRL:   rdata_c = ctrl_word(sel_c);
        REG_RELOAD: rdata_c = DATA_W'(sel_c.reload);
        REG_COUNT:  rdata_c = DATA_W'(sel_c.count);
        default:    rdata_c = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_ms4   <= '0;
      tick_armed <= 1'b0;
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
      irq        <= 1'b0;
    end else begin
      prev_ms4   <= time_ms4;
      tick_armed <= 1'b1;
      bus_rvalid <= bus_rd;
      if (bus_rd) bus_rdata <= rdata_c;
      irq        <= irq_c;
    end
  end

endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm with hand-computed expectations.
module tb_timer_alarm;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] time_ms4;
  logic [4:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_rvalid;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] tm;
  logic [15:0] d;

  timer_alarm #(.CHANNELS(4), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .time_ms4   (time_ms4),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_rd     (bus_rd),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] addr(input int ch, input int r);
    return 5'(ch * 4 + r);
  endfunction

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic tick();
    tm = tm + 16'd1;
    time_ms4 = tm;
    cyc();
  endtask

  task automatic jump(input logic [15:0] v);
    tm = v;
    time_ms4 = v;
    cyc();
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] v);
    bus_addr = a; bus_wdata = v; bus_wr = 1'b1;
    cyc();
    bus_wr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] v);
    bus_addr = a; bus_rd = 1'b1;
    cyc();
    bus_rd = 1'b0;
    v = bus_rdata;
  endtask

  task automatic test_reset();
    reset = 1'b0; time_ms4 = 16'd1; tm = 16'd1;
    bus_addr = '0; bus_wr = 1'b0; bus_rd = 1'b0; bus_wdata = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus_rdata, bus_rvalid, irq} !== 18'd0) begin
      errors++; $display("FAIL por_outputs got %h exp 0", {bus_rdata, bus_rvalid, irq});
    end
    reset = 1'b1;
    cyc();
    wr(addr(0, 1), 16'd5);
    wr(addr(0, 0), 16'h9);
    tick(); tick();
    rd(addr(0, 2), d);
    checks++;
    if (d !== 16'd3) begin errors++; $display("FAIL pre_reset_count got %h exp 3", d); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus_rdata, bus_rvalid, irq} !== 18'd0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {bus_rdata, bus_rvalid, irq});
    end
    time_ms4 = 16'd1; tm = 16'd1;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (dut.tick_c !== 1'b0) begin errors++; $display("FAIL tick_after_release got %b exp 0", dut.tick_c); end
    @(negedge clock);
    rd(addr(0, 0), d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
    rd(addr(0, 1), d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL reset_reload got %h exp 0", d); end
    rd(addr(0, 2), d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL reset_count got %h exp 0", d); end
  endtask

  task automatic test_one_shot();
    wr(addr(1, 1), 16'd3);
    wr(addr(1, 0), 16'h9);
    tick(); tick(); tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", irq); end
    cyc();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq got %b exp 1", irq); end
    rd(addr(1, 0), d);
    checks++;
    if (d !== 16'hC) begin errors++; $display("FAIL oneshot_ctrl got %h exp c", d); end
    rd(addr(1, 2), d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL oneshot_count got %h exp 0", d); end
    wr(addr(1, 0), 16'hC);
    cyc();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
    rd(addr(1, 0), d);
    checks++;
    if (d !== 16'h8) begin errors++; $display("FAIL w1c_ctrl got %h exp 8", d); end
  endtask

  task automatic test_periodic_wrap();
    jump(16'hFFFD);
    wr(addr(2, 1), 16'd2);
    wr(addr(2, 0), 16'hB);
    tick(); tick();
    rd(addr(2, 0), d);
    checks++;
    if (d !== 16'hF) begin errors++; $display("FAIL periodic_ctrl1 got %h exp f", d); end
    rd(addr(2, 2), d);
    checks++;
    if (d !== 16'd2) begin errors++; $display("FAIL periodic_reload1 got %h exp 2", d); end
    wr(addr(2, 0), 16'hF);
    tick();
    rd(addr(2, 2), d);
    checks++;
    if (d !== 16'd1) begin errors++; $display("FAIL wrap_tick got %h exp 1", d); end
    tick();
    rd(addr(2, 0), d);
    checks++;
    if (d !== 16'hF) begin errors++; $display("FAIL periodic_ctrl2 got %h exp f", d); end
    rd(addr(2, 2), d);
    checks++;
    if (d !== 16'd2) begin errors++; $display("FAIL periodic_reload2 got %h exp 2", d); end
    wr(addr(2, 0), 16'h4);
  endtask

  task automatic test_non_tick_jump();
    wr(addr(3, 1), 16'd4);
    wr(addr(3, 0), 16'h1);
    jump(16'h0100); jump(16'h0000); jump(16'h0005);
    rd(addr(3, 2), d);
    checks++;
    if (d !== 16'd4) begin errors++; $display("FAIL jump_count got %h exp 4", d); end
    tick();
    rd(addr(3, 2), d);
    checks++;
    if (d !== 16'd3) begin errors++; $display("FAIL after_jump_tick got %h exp 3", d); end
    wr(addr(3, 0), 16'h0);
  endtask

  task automatic test_collisions();
    // W1C of pending on the expiry tick
    wr(addr(1, 0), 16'h3);
    tick(); tick();
    tm = tm + 16'd1; time_ms4 = tm;
    bus_addr = addr(1, 0); bus_wdata = 16'h7; bus_wr = 1'b1;
    cyc();
    bus_wr = 1'b0;
    rd(addr(1, 0), d);
    checks++;
    if (d !== 16'h7) begin errors++; $display("FAIL w1c_vs_expiry got %h exp 7", d); end
    rd(addr(1, 2), d);
    checks++;
    if (d !== 16'd3) begin errors++; $display("FAIL w1c_vs_expiry_count got %h exp 3", d); end
    // RELOAD write on the reload tick
    wr(addr(1, 0), 16'h7);
    tick(); tick();
    tm = tm + 16'd1; time_ms4 = tm;
    bus_addr = addr(1, 1); bus_wdata = 16'd7; bus_wr = 1'b1;
    cyc();
    bus_wr = 1'b0;
    rd(addr(1, 2), d);
    checks++;
    if (d !== 16'd3) begin errors++; $display("FAIL reload_collision_count got %h exp 3", d); end
    rd(addr(1, 1), d);
    checks++;
    if (d !== 16'd7) begin errors++; $display("FAIL reload_collision_reload got %h exp 7", d); end
    tick(); tick(); tick();
    rd(addr(1, 2), d);
    checks++;
    if (d !== 16'd7) begin errors++; $display("FAIL new_period got %h exp 7", d); end
    wr(addr(1, 0), 16'h4);
    // Arming write on a tick cycle loads instead of decrementing
    tm = tm + 16'd1; time_ms4 = tm;
    bus_addr = addr(3, 0); bus_wdata = 16'h1; bus_wr = 1'b1;
    cyc();
    bus_wr = 1'b0;
    rd(addr(3, 2), d);
    checks++;
    if (d !== 16'd4) begin errors++; $display("FAIL enable_on_tick got %h exp 4", d); end
    wr(addr(3, 0), 16'h0);
  endtask

  task automatic test_bus();
    wr(addr(0, 0), 16'hB);
    rd(addr(0, 0), d);
    checks++;
    if (d !== 16'hA) begin errors++; $display("FAIL enable_reload0 got %h exp a", d); end
    rd(addr(5, 0), d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL bad_channel got %h exp 0", d); end
    wr(addr(3, 2), 16'h55);
    rd(addr(3, 2), d);
    checks++;
    if (d !== 16'd4) begin errors++; $display("FAIL count_readonly got %h exp 4", d); end
    rd(addr(1, 3), d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL reserved_reg got %h exp 0", d); end
    cyc();
    checks++;
    if (bus_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_idle got %b exp 0", bus_rvalid); end
    bus_addr = addr(0, 1); bus_wdata = 16'h1234; bus_rd = 1'b1; bus_wr = 1'b1;
    cyc();
    bus_rd = 1'b0; bus_wr = 1'b0;
    checks++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 16'h0) begin
      errors++; $display("FAIL rd_wr_same got rvalid %b data %h exp 1 0000", bus_rvalid, bus_rdata);
    end
    cyc();
    checks++;
    if (bus_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one_cycle got %b exp 0", bus_rvalid); end
    rd(addr(0, 1), d);
    checks++;
    if (d !== 16'h1234) begin errors++; $display("FAIL reload_after_rdwr got %h exp 1234", d); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic_wrap();
    test_non_tick_jump();
    test_collisions();
    test_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
